// File: rtl/dcache_pkg.sv
// Shared types, constants and helpers for the L1 dCache data path.
package dcache_pkg;

   localparam int unsigned WORD_BYTES     = 4;
   localparam int unsigned LINE_WORDS_DEF = 8;
   localparam int unsigned OFF_W          = $clog2(LINE_WORDS_DEF);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } fill_state_t;

   // Replace only the byte lanes selected by strb.
   function automatic logic [31:0] merge_word(input logic [31:0]           old_w,
                                              input logic [31:0]           new_w,
                                              input logic [WORD_BYTES-1:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
         if (strb[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dcache_data_bank_if.sv
// Controller/refill-side bus of the dCache data bank.
interface dcache_data_bank_if
   import dcache_pkg::*;
#(
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS_LOG2  = 7,
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned WORD_W     = 32
);
   localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);

   logic                      rd_en;
   logic [SETS_LOG2-1:0]      rd_set;
   logic [OFF_BITS-1:0]       rd_word;
   logic [WAYS*WORD_W-1:0]    rd_data;
   logic                      rd_valid;

   logic                      wr_en;
   logic                      wr_ready;
   logic [WAY_W-1:0]          wr_way;
   logic [SETS_LOG2-1:0]      wr_set;
   logic [OFF_BITS-1:0]       wr_word;
   logic [WORD_BYTES-1:0]     wr_strb;
   logic [WORD_W-1:0]         wr_data;

   logic                      fill_start;
   logic [WAY_W-1:0]          fill_way;
   logic [SETS_LOG2-1:0]      fill_set;
   logic [OFF_BITS-1:0]       fill_word;
   logic                      fill_valid;
   logic [WORD_W-1:0]         fill_data;
   logic                      fill_ready;
   logic                      fill_busy;
   logic                      fill_done;

   modport master (
      output rd_en, rd_set, rd_word,
      input  rd_data, rd_valid,
      output wr_en, wr_way, wr_set, wr_word, wr_strb, wr_data,
      input  wr_ready,
      output fill_start, fill_way, fill_set, fill_word, fill_valid, fill_data,
      input  fill_ready, fill_busy, fill_done
   );

   modport slave (
      input  rd_en, rd_set, rd_word,
      output rd_data, rd_valid,
      input  wr_en, wr_way, wr_set, wr_word, wr_strb, wr_data,
      output wr_ready,
      input  fill_start, fill_way, fill_set, fill_word, fill_valid, fill_data,
      output fill_ready, fill_busy, fill_done
   );

endinterface

// File: rtl/dcache_way_ram.sv
// One way of the data array: 1W/1R, byte write enables, registered read with write-first bypass.
module dcache_way_ram
   import dcache_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [WORD_BYTES-1:0] wbe,
   input  logic [31:0]           wdata,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [31:0]           rdata
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [31:0] mem_q [DEPTH];
   logic [31:0] merged;
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      merged  = merge_word(mem_q[waddr], wdata, wbe);
      rdata_d = rdata_q;
      if (re) rdata_d = (we && (waddr == raddr)) ? merged : mem_q[raddr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q   <= '{default: '0};
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
         if (we) mem_q[waddr] <= merged;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dcache_data_bank.sv
// Multi-way dCache data bank: parallel way reads, strobed store hits, critical-word-first refill.
module dcache_data_bank
   import dcache_pkg::*;
#(
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS_LOG2  = 7,
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned WORD_W     = 32
) (
   input logic               clk,
   input logic               reset,
   dcache_data_bank_if.slave bus
);
   localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned OFFS   = $clog2(LINE_WORDS);
   localparam int unsigned ADDR_W = SETS_LOG2 + OFFS;

   fill_state_t          state_q, state_d;
   logic [WAY_W-1:0]     fway_q, fway_d;
   logic [SETS_LOG2-1:0] fset_q, fset_d;
   logic [OFFS-1:0]      fword_q, fword_d;
   logic [OFFS-1:0]      beat_q, beat_d;
   logic                 rd_valid_q, rd_valid_d;

   logic                  fill_ready, fill_busy, fill_done;
   logic                  beat_fire, hit_fill_line, wr_ready, st_fire;
   logic [OFFS-1:0]       fill_off;
   logic                  port_we;
   logic [WAY_W-1:0]      port_way;
   logic [ADDR_W-1:0]     port_addr;
   logic [WORD_BYTES-1:0] port_be;
   logic [31:0]           port_data;

   always_comb begin
      state_d    = state_q;
      fway_d     = fway_q;
      fset_d     = fset_q;
      fword_d    = fword_q;
      beat_d     = beat_q;
      rd_valid_d = bus.rd_en;

      fill_ready    = !reset && (state_q == FILL);
      fill_busy     = !reset && (state_q == FILL);
      fill_done     = !reset && (state_q == DONE);
      beat_fire     = fill_ready && bus.fill_valid;
      // Stores into the line under refill wait, otherwise a later beat would overwrite them.
      hit_fill_line = fill_busy && (bus.wr_set == fset_q) && (bus.wr_way == fway_q);
      wr_ready      = !reset && !beat_fire && !hit_fill_line;
      st_fire       = bus.wr_en && wr_ready;
      fill_off      = fword_q + beat_q;

      port_we   = st_fire;
      port_way  = bus.wr_way;
      port_addr = {bus.wr_set, bus.wr_word};
      port_be   = bus.wr_strb;
      port_data = bus.wr_data;
      if (beat_fire) begin
         port_we   = 1'b1;
         port_way  = fway_q;
         port_addr = {fset_q, fill_off};
         port_be   = '1;
         port_data = bus.fill_data;
      end

      case (state_q)
         IDLE: begin
            if (bus.fill_start) begin
               fway_d  = bus.fill_way;
               fset_d  = bus.fill_set;
               fword_d = bus.fill_word;
               beat_d  = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            if (bus.fill_valid) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == OFFS'(LINE_WORDS - 1)) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fway_q     <= '0;
         fset_q     <= '0;
         fword_q    <= '0;
         beat_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fway_q     <= fway_d;
         fset_q     <= fset_d;
         fword_q    <= fword_d;
         beat_q     <= beat_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   logic [31:0]            way_rd [WAYS];
   logic [WAYS*WORD_W-1:0] rd_data;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic way_we;
      assign way_we = port_we && (port_way == WAY_W'(w));

      dcache_way_ram #(.ADDR_W(ADDR_W)) u_ram (
         .clk   (clk),
         .reset (reset),
         .we    (way_we),
         .waddr (port_addr),
         .wbe   (port_be),
         .wdata (port_data),
         .re    (bus.rd_en),
         .raddr ({bus.rd_set, bus.rd_word}),
         .rdata (way_rd[w])
      );
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned w = 0; w < WAYS; w++) rd_data[w*WORD_W +: WORD_W] = way_rd[w];
   end

   assign bus.rd_data    = rd_data;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.wr_ready   = wr_ready;
   assign bus.fill_ready = fill_ready;
   assign bus.fill_busy  = fill_busy;
   assign bus.fill_done  = fill_done;

endmodule

// File: doc/dcache_data_bank.md
Name: dcache_data_bank

Overview:
- Multi-way data array for the L1 dCache; successor to the single-way, unregistered data RAM.
- Holds WAYS x 2**SETS_LOG2 lines of LINE_WORDS 32-bit words.
- Serves registered word reads across all ways in parallel, byte-strobed store hits, and critical-word-first line refills from the bus side.
- Sits between the dCache controller (tag compare, way select) and the AXI refill path.

Parameters:
WAYS, 2, number of ways (power of two, >=1)
SETS_LOG2, 7, log2 of set count
LINE_WORDS, 8, 32-bit words per line (power of two, >=2)
WORD_W, 32, word width (fixed at 32; byte strobes are WORD_W/8)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rd_en  in  1  read request
rd_set  in  SETS_LOG2  read set index
rd_word  in  log2(LINE_WORDS)  word offset in line
rd_data  out  WAYS*WORD_W  word from each way; way w at [w*32 +: 32]
rd_valid  out  1  rd_data valid (one cycle after rd_en)
wr_en  in  1  store-hit write request
wr_ready  out  1  store accepted this cycle
wr_way  in  log2(WAYS)  target way
wr_set  in  SETS_LOG2  target set
wr_word  in  log2(LINE_WORDS)  target word
wr_strb  in  4  byte enables
wr_data  in  WORD_W  store data (byte lanes already aligned)
fill_start  in  1  begin line refill (accepted only in IDLE)
fill_way  in  log2(WAYS)  refill way
fill_set  in  SETS_LOG2  refill set
fill_word  in  log2(LINE_WORDS)  critical word, delivered first
fill_valid  in  1  refill beat valid
fill_data  in  WORD_W  refill beat
fill_ready  out  1  bank can accept a beat
fill_busy  out  1  refill in progress
fill_done  out  1  one-cycle pulse after the last beat is written

Behaviour:
- Reset:
  - Clears the entire array to 0.
  - Outputs: rd_data=0, rd_valid=0, fill_ready=0, fill_busy=0, fill_done=0; FSM to IDLE.
  - wr_ready=0 during reset, 1 afterwards.
- Reset mid-refill aborts the refill; the partially written line is zeroed with the rest of the array.
- Read:
  - rd_en sampled at edge N; rd_data/rd_valid are valid after edge N; rd_valid is high for exactly one cycle per rd_en.
  - rd_data holds its value while rd_en=0.
  - Write-first: a write (store or fill beat) accepted at the same edge to the same set/word is visible in rd_data for that way. For stores the visible value is the byte-merged word.
- Store:
  - Accepted when wr_en && wr_ready.
  - Writes only bytes with wr_strb[i]=1.
  - wr_strb=0 is a legal no-op and is still acknowledged.
- Single write port; a fill beat has priority:
  - wr_ready = !(fill_valid && fill_ready).
  - wr_ready is also 0 when fill_busy and wr_set/wr_way equal the line being refilled, so stores cannot be lost to the refill.
- Refill FSM: IDLE -> FILL -> DONE -> IDLE.
  - IDLE: fill_ready=0. On fill_start, latch way/set/word, clear the beat counter, go to FILL; fill_busy=1 from the next cycle.
  - FILL: fill_ready=1. Each fill_valid beat writes the full word at (latched_word + beat_cnt) mod LINE_WORDS, wrapping past the top of the line, then increments beat_cnt. The beat with beat_cnt==LINE_WORDS-1 goes to DONE. fill_valid gaps stall without side effects.
  - DONE: fill_done=1 and fill_ready=0 for one cycle; fill_busy drops with it; return to IDLE.
  - fill_start outside IDLE is ignored.
- Width rules:
  - Word address within a way is {set, word}.
  - Beat offset uses modulo-LINE_WORDS arithmetic: the carry is discarded.

Decomposition:
- Shared package dcache_pkg:
  - localparams WORD_BYTES=4 and OFF_W=$clog2(LINE_WORDS).
  - typedef fill_state_t {IDLE, FILL, DONE}.
  - Helper function for strobe-merging a word.
- Sub-module dcache_way_ram, instantiated WAYS times:
  - One-write/one-read array with per-byte write enable, registered read and write-first bypass.
  - Top level holds the refill FSM, write arbitration and way decode.

Test Plan:
1. After reset: read set 5, word 3 -> rd_valid pulses one cycle later; rd_data=0 on all ways.
2. Store way 1, set 10, word 2, data 0xAABBCCDD, strb 4'b0101; then read -> way 1 word = 0x00BB00DD; way 0 unchanged.
3. Refill way 0, set 3, fill_word=6, LINE_WORDS=8, beats 0x100..0x107 -> words 6,7,0,1,...,5 hold 0x100..0x107. fill_done pulses once after the 8th beat. fill_ready drops.
4. Refill with fill_valid deasserted for 3 cycles mid-line -> no extra writes; completion after exactly 8 valid beats.
5. Store to a different line while a beat is valid -> wr_ready=0 that cycle, store lands the next cycle. Store to the line being refilled -> wr_ready=0 until fill_done.
6. Read and store to the same set/word in one cycle, strb 4'b1111, data 0x12345678 -> rd_data shows 0x12345678 for that way. Assert reset during FILL -> FSM IDLE, fill_busy=0, array zeroed.
